// File: rtl/mod_settings_loader.sv
// mod_settings_loader: polls the CPU request flag in the controller BRAM,
// reads the 12-word modulation configuration block into staging registers
// and publishes it atomically to the modulation engine with a 1-cycle UPDATE.
// Optional build macro: MOD_SETTINGS_LOADER_VALIDATE_EN (reject zero
// FREQ_DIV / CYCLE values and pulse ERR instead of committing).

package settings;
    typedef struct packed {
        logic             UPDATE;
        logic             REQ_RD_SEGMENT;
        logic [7:0]       TRANSITION_MODE;
        logic [63:0]      TRANSITION_VALUE;
        logic [1:0][14:0] CYCLE;
        logic [1:0][15:0] FREQ_DIV;
        logic [1:0][15:0] REP;
    } mod_settings_t;
endpackage

module mod_settings_loader #(
    parameter int         BRAM_LATENCY = 2,
    parameter logic [7:0] CTL_ADDR     = 8'h00,
    parameter logic [7:0] BASE_ADDR    = 8'h10
) (
    input  logic                   CLK,
    input  logic                   RST,
    output logic [7:0]             BRAM_ADDR,
    input  logic [15:0]            BRAM_DOUT,
    output settings::mod_settings_t MOD_SETTINGS,
    output logic                   BUSY,
    output logic                   ERR
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

    localparam logic [3:0] LAST_IDX = 4'd11;
    localparam logic [2:0] LAT      = 3'(BRAM_LATENCY);
    localparam settings::mod_settings_t RESET_VAL = settings::mod_settings_t'({
        1'b0, 1'b0, 8'd0, 64'd0,
        {2{15'd1}}, {2{16'd10}}, {2{16'hFFFF}}});

    state_t                   state_reg, state_next;
    logic [3:0]               idx_reg, idx_next;
    logic [2:0]               idle_cnt_reg;
    logic                     hist_reg;
    logic [BRAM_LATENCY-1:0]  pipe_vld_reg;
    logic [BRAM_LATENCY-1:0][3:0] pipe_idx_reg;
    settings::mod_settings_t  stage_reg, stage_next;
    settings::mod_settings_t  out_reg;

    logic       poll_valid;
    logic       trig;
    logic       cap_vld;
    logic [3:0] cap_idx;
    logic       commit_now;
    logic       commit_ok;

    // Poll data is trusted only once the read pipeline holds CTL_ADDR returns
    assign poll_valid = (state_reg == IDLE) && (idle_cnt_reg == LAT);
    assign trig       = poll_valid && BRAM_DOUT[0] && !hist_reg;
    assign cap_vld    = pipe_vld_reg[BRAM_LATENCY-1];
    assign cap_idx    = pipe_idx_reg[BRAM_LATENCY-1];
    assign commit_now = (state_reg == DRAIN) && cap_vld && (cap_idx == LAST_IDX);

    assign BRAM_ADDR    = (state_reg == LOAD) ? (BASE_ADDR + {4'd0, idx_reg}) : CTL_ADDR;
    assign BUSY         = (state_reg != IDLE) || trig;
    assign MOD_SETTINGS = out_reg;

`ifdef MOD_SETTINGS_LOADER_VALIDATE_EN
    logic err_reg;

    assign commit_ok = (stage_next.FREQ_DIV[0] != 16'd0) && (stage_next.FREQ_DIV[1] != 16'd0)
                    && (stage_next.CYCLE[0] != 15'd0) && (stage_next.CYCLE[1] != 15'd0);
    assign ERR = err_reg;

    // One-cycle reject strobe in place of UPDATE when staged values are unusable
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= commit_now && !commit_ok;
        end
    end
`else
    assign commit_ok = 1'b1;
    assign ERR       = 1'b0;
`endif

    // Next-state and word-index sequencing
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                idx_next = 4'd0;
                if (trig) state_next = LOAD;
            end
            LOAD: begin
                idx_next = idx_reg + 4'd1;
                if (idx_reg == LAST_IDX) state_next = DRAIN;
            end
            DRAIN: begin
                if (commit_now) state_next = COMMIT;
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Steer the returning word into its staging field
    always_comb begin
        stage_next = stage_reg;
        if (cap_vld) begin
            case (cap_idx)
                4'd0:  stage_next.REQ_RD_SEGMENT         = BRAM_DOUT[0];
                4'd1:  stage_next.TRANSITION_MODE        = BRAM_DOUT[7:0];
                4'd2:  stage_next.TRANSITION_VALUE[15:0]  = BRAM_DOUT;
                4'd3:  stage_next.TRANSITION_VALUE[31:16] = BRAM_DOUT;
                4'd4:  stage_next.TRANSITION_VALUE[47:32] = BRAM_DOUT;
                4'd5:  stage_next.TRANSITION_VALUE[63:48] = BRAM_DOUT;
                4'd6:  stage_next.CYCLE[0]    = BRAM_DOUT[14:0];
                4'd7:  stage_next.CYCLE[1]    = BRAM_DOUT[14:0];
                4'd8:  stage_next.FREQ_DIV[0] = BRAM_DOUT;
                4'd9:  stage_next.FREQ_DIV[1] = BRAM_DOUT;
                4'd10: stage_next.REP[0]      = BRAM_DOUT;
                4'd11: stage_next.REP[1]      = BRAM_DOUT;
                default: ;
            endcase
        end
    end

    // FSM state, word index and IDLE dwell counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            idx_reg      <= 4'd0;
            idle_cnt_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (state_reg != IDLE) begin
                idle_cnt_reg <= 3'd0;
            end else if (idle_cnt_reg != LAT) begin
                idle_cnt_reg <= idle_cnt_reg + 3'd1;
            end
        end
    end

    // Flag history: last valid poll sample; forced high on commit so a held flag never re-fires
    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_reg <= 1'b0;
        end else if (poll_valid) begin
            hist_reg <= BRAM_DOUT[0];
        end else if (state_reg == COMMIT) begin
            hist_reg <= 1'b1;
        end
    end

    // Delayed index pipeline matching the BRAM read latency
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_vld_reg <= '0;
            pipe_idx_reg <= '0;
        end else begin
            pipe_vld_reg[0] <= (state_reg == LOAD);
            pipe_idx_reg[0] <= idx_reg;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_idx_reg[i] <= pipe_idx_reg[i-1];
            end
        end
    end

    // Staging registers and atomic publish; the last word is forwarded straight into the commit
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_reg <= RESET_VAL;
            out_reg   <= RESET_VAL;
        end else begin
            stage_reg      <= stage_next;
            out_reg.UPDATE <= 1'b0;
            if (commit_now && commit_ok) begin
                out_reg        <= stage_next;
                out_reg.UPDATE <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_settings_loader.sv
// Scoreboard bench for mod_settings_loader: a behavioural BRAM with
// BRAM_LATENCY read delay, expected settings queued when a request edge is
// driven and compared whenever the DUT strobes UPDATE.
module tb_mod_settings_loader;

    localparam int         L    = 2;
    localparam logic [7:0] CTL  = 8'h00;
    localparam logic [7:0] BASE = 8'h10;

    logic                    CLK = 1'b0;
    logic                    RST = 1'b1;
    logic [7:0]              BRAM_ADDR;
    logic [15:0]             BRAM_DOUT;
    settings::mod_settings_t MOD_SETTINGS;
    logic                    BUSY;
    logic                    ERR;

    mod_settings_loader #(.BRAM_LATENCY(L), .CTL_ADDR(CTL), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST), .BRAM_ADDR(BRAM_ADDR), .BRAM_DOUT(BRAM_DOUT),
        .MOD_SETTINGS(MOD_SETTINGS), .BUSY(BUSY), .ERR(ERR));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // behavioural BRAM: address sampled at a rising edge, data L cycles later
    logic [15:0] mem [256];
    logic [15:0] rd_pipe [L];
    always @(posedge CLK) begin
        rd_pipe[0] <= mem[BRAM_ADDR];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign BRAM_DOUT = rd_pipe[L-1];

    int n_checks = 0;
    int n_bad    = 0;
    int upd_cnt  = 0;
    int err_cnt  = 0;
    int last_upd = -1;
    settings::mod_settings_t exp_q[$];
    settings::mod_settings_t mon_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cmp_settings(input string tag, input settings::mod_settings_t got,
                                input settings::mod_settings_t exp);
        check({tag, "_seg"},  64'(got.REQ_RD_SEGMENT),   64'(exp.REQ_RD_SEGMENT));
        check({tag, "_mode"}, 64'(got.TRANSITION_MODE),  64'(exp.TRANSITION_MODE));
        check({tag, "_tv"},   got.TRANSITION_VALUE,      exp.TRANSITION_VALUE);
        check({tag, "_cyc0"}, 64'(got.CYCLE[0]),    64'(exp.CYCLE[0]));
        check({tag, "_cyc1"}, 64'(got.CYCLE[1]),    64'(exp.CYCLE[1]));
        check({tag, "_fd0"},  64'(got.FREQ_DIV[0]), 64'(exp.FREQ_DIV[0]));
        check({tag, "_fd1"},  64'(got.FREQ_DIV[1]), 64'(exp.FREQ_DIV[1]));
        check({tag, "_rep0"}, 64'(got.REP[0]),      64'(exp.REP[0]));
        check({tag, "_rep1"}, 64'(got.REP[1]),      64'(exp.REP[1]));
    endtask

    function automatic settings::mod_settings_t mk(
        input logic seg, input logic [7:0] mode, input logic [63:0] tv,
        input logic [14:0] c0, input logic [14:0] c1, input logic [15:0] f0,
        input logic [15:0] f1, input logic [15:0] r0, input logic [15:0] r1);
        settings::mod_settings_t s;
        s.UPDATE = 1'b1;
        s.REQ_RD_SEGMENT = seg;
        s.TRANSITION_MODE = mode;
        s.TRANSITION_VALUE = tv;
        s.CYCLE[0] = c0;    s.CYCLE[1] = c1;
        s.FREQ_DIV[0] = f0; s.FREQ_DIV[1] = f1;
        s.REP[0] = r0;      s.REP[1] = r1;
        return s;
    endfunction

    // configuration words, with junk in the bits the loader must ignore
    task automatic write_cfg(input settings::mod_settings_t s);
        mem[BASE + 8'd0]  = {15'h7AAA, s.REQ_RD_SEGMENT};
        mem[BASE + 8'd1]  = {8'hC3, s.TRANSITION_MODE};
        mem[BASE + 8'd2]  = s.TRANSITION_VALUE[15:0];
        mem[BASE + 8'd3]  = s.TRANSITION_VALUE[31:16];
        mem[BASE + 8'd4]  = s.TRANSITION_VALUE[47:32];
        mem[BASE + 8'd5]  = s.TRANSITION_VALUE[63:48];
        mem[BASE + 8'd6]  = {1'b1, s.CYCLE[0]};
        mem[BASE + 8'd7]  = {1'b1, s.CYCLE[1]};
        mem[BASE + 8'd8]  = s.FREQ_DIV[0];
        mem[BASE + 8'd9]  = s.FREQ_DIV[1];
        mem[BASE + 8'd10] = s.REP[0];
        mem[BASE + 8'd11] = s.REP[1];
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic idle_zero();
        mem[CTL] = 16'h0000;
        repeat (6) @(negedge CLK);
    endtask

    // raise the flag at this negedge; returns the cycle its poll data becomes valid
    task automatic kick(output int t);
        mem[CTL] = 16'h0001;
        t = cyc + L;
    endtask

    // output monitor: every UPDATE pops one expected record
    always @(negedge CLK) begin
        if (!RST) begin
            if (ERR) begin
                err_cnt++;
                $display("err strobe at cycle %0d", cyc);
            end
            if (MOD_SETTINGS.UPDATE) begin
                upd_cnt++;
                last_upd = cyc;
                $display("update #%0d at cycle %0d tv=%h", upd_cnt, cyc,
                         MOD_SETTINGS.TRANSITION_VALUE);
                if (exp_q.size() == 0) begin
                    check("spurious_update", 64'd1, 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    cmp_settings("upd", MOD_SETTINGS, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        settings::mod_settings_t rst_exp, cfg_a, cfg_b, cfg_c, cfg_d, cfg_e;
        int t, u0;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_exp = mk(1'b0, 8'h00, 64'd0, 15'd1, 15'd1, 16'd10, 16'd10, 16'hFFFF, 16'hFFFF);
        cfg_a = mk(1'b1, 8'h02, 64'h0123_4567_89AB_CDEF, 15'd100, 15'd200, 16'd40, 16'd80, 16'd3, 16'd0);
        cfg_b = mk(1'b0, 8'hA5, 64'hFEDC_BA98_7654_3210, 15'h7FFF, 15'd1, 16'hFFFF, 16'd1, 16'h1234, 16'hFFFF);
        cfg_c = mk(1'b1, 8'h11, 64'h1111_2222_3333_4444, 15'd5, 15'd6, 16'd7, 16'd8, 16'd9, 16'd10);
        cfg_d = mk(1'b0, 8'h3C, 64'h0000_0000_0000_0000, 15'd12, 15'd34, 16'd56, 16'd78, 16'd0, 16'd0);
        cfg_e = cfg_a;
        cfg_e.FREQ_DIV[1] = 16'd0;

        // 1: reset values
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        cmp_settings("rst", MOD_SETTINGS, rst_exp);
        check("rst_update", 64'(MOD_SETTINGS.UPDATE), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        check("rst_addr", 64'(BRAM_ADDR), 64'(CTL));
        RST = 1'b0;
        @(negedge CLK);

        // 2: basic load and exact latency
        write_cfg(cfg_a);
        idle_zero();
        u0 = upd_cnt;
        kick(t);
        exp_q.push_back(cfg_a);
        $display("request A driven, poll valid at cycle %0d", t);
        wait_until(t - 1);
        check("busy_before", 64'(BUSY), 64'd0);
        wait_until(t);
        check("busy_at_t", 64'(BUSY), 64'd1);
        wait_until(t + 1);
        check("addr_first", 64'(BRAM_ADDR), 64'(BASE));
        wait_until(t + 14);
        check("no_early_update", 64'(upd_cnt - u0), 64'd0);
        check("busy_t14", 64'(BUSY), 64'd1);
        wait_until(t + 15);
        check("busy_t15", 64'(BUSY), 64'd1);
        wait_until(t + 16);
        check("upd_cycle", 64'(last_upd), 64'(t + 15));
        check("upd_count_a", 64'(upd_cnt - u0), 64'd1);
        check("busy_after", 64'(BUSY), 64'd0);
        check("update_low_after", 64'(MOD_SETTINGS.UPDATE), 64'd0);
        cmp_settings("hold_a", MOD_SETTINGS, cfg_a);

        // 3: held flag fires once, new 0->1 edge fires again
        repeat (100) @(negedge CLK);
        check("held_flag_once", 64'(upd_cnt - u0), 64'd1);
        write_cfg(cfg_b);
        idle_zero();
        kick(t);
        exp_q.push_back(cfg_b);
        $display("request B driven, poll valid at cycle %0d", t);
        wait_until(t + 25);
        check("upd_count_b", 64'(upd_cnt - u0), 64'd2);

        // 4: reset during LOAD word 5
        write_cfg(cfg_c);
        idle_zero();
        u0 = upd_cnt;
        kick(t);
        $display("request C driven (to be reset mid-load), poll valid at cycle %0d", t);
        wait_until(t + 6);
        check("addr_word5", 64'(BRAM_ADDR), 64'(BASE + 8'd5));
        RST = 1'b1;
        mem[CTL] = 16'h0000;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        cmp_settings("midrst", MOD_SETTINGS, rst_exp);
        check("midrst_busy", 64'(BUSY), 64'd0);
        check("midrst_addr", 64'(BRAM_ADDR), 64'(CTL));
        repeat (30) @(negedge CLK);
        check("midrst_no_update", 64'(upd_cnt - u0), 64'd0);
        cmp_settings("midrst_hold", MOD_SETTINGS, rst_exp);
        kick(t);
        exp_q.push_back(cfg_c);
        $display("request C driven after reset, poll valid at cycle %0d", t);
        wait_until(t + 16);
        check("post_rst_upd_cycle", 64'(last_upd), 64'(t + 15));
        check("post_rst_count", 64'(upd_cnt - u0), 64'd1);

        // 5: flag toggles during LOAD are ignored
        write_cfg(cfg_d);
        idle_zero();
        u0 = upd_cnt;
        kick(t);
        exp_q.push_back(cfg_d);
        $display("request D driven with toggles, poll valid at cycle %0d", t);
        wait_until(t + 4);
        mem[CTL] = 16'h0000;
        wait_until(t + 7);
        mem[CTL] = 16'h0001;
        wait_until(t + 60);
        check("toggle_single_update", 64'(upd_cnt - u0), 64'd1);
        idle_zero();
        kick(t);
        exp_q.push_back(cfg_d);
        $display("request D re-armed, poll valid at cycle %0d", t);
        wait_until(t + 25);
        check("rearm_update", 64'(upd_cnt - u0), 64'd2);

        // 6: zero FREQ_DIV[1]
        write_cfg(cfg_e);
        idle_zero();
        u0 = upd_cnt;
        kick(t);
`ifdef MOD_SETTINGS_LOADER_VALIDATE_EN
        $display("request E (invalid) driven, poll valid at cycle %0d", t);
        wait_until(t + 25);
        check("val_err_pulses", 64'(err_cnt), 64'd1);
        check("val_no_update", 64'(upd_cnt - u0), 64'd0);
        cmp_settings("val_hold", MOD_SETTINGS, cfg_d);
`else
        exp_q.push_back(cfg_e);
        $display("request E (fd1=0) driven, poll valid at cycle %0d", t);
        wait_until(t + 25);
        check("noval_err", 64'(err_cnt), 64'd0);
        check("noval_update", 64'(upd_cnt - u0), 64'd1);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
